// File: rtl/lru_pkg.sv
// Shared types and helpers for the true-LRU age array: operation encoding,
// index-width calculation and the per-way reset age.
package lru_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_TOUCH = 2'd1,
    OP_INVAL = 2'd2
  } lru_op_e;

  function automatic int calc_way_w(input int ways);
    return (ways < 2) ? 1 : $clog2(ways);
  endfunction

  // A single-set array still carries a 1-bit set index so ports never collapse to zero width.
  function automatic int calc_set_w(input int sets);
    return (sets < 2) ? 1 : $clog2(sets);
  endfunction

  function automatic int unsigned reset_age(input int unsigned way);
    return way;
  endfunction

endpackage

// File: rtl/lru_age_set.sv
// Combinational next-age and victim logic for one set's age permutation.
// Touch promotes a way to MRU (age 0); inval demotes it to LRU (age WAYS-1).
module lru_age_set
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS-1:0][WAY_W-1:0] age_cur,
  input  logic [1:0]                 op,
  input  logic [WAY_W-1:0]           way,
  output logic [WAYS-1:0][WAY_W-1:0] age_nxt,
  output logic [WAY_W-1:0]           victim
);

  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  logic [WAY_W-1:0] sel_age;

  always_comb begin
    sel_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way == WAY_W'(w)) sel_age = age_cur[w];
    end
  end

  always_comb begin
    age_nxt = age_cur;
    case (op)
      OP_TOUCH: begin
        for (int w = 0; w < WAYS; w++) begin
          if (way == WAY_W'(w))          age_nxt[w] = '0;
          else if (age_cur[w] < sel_age) age_nxt[w] = age_cur[w] + 1'b1;
        end
      end
      OP_INVAL: begin
        for (int w = 0; w < WAYS; w++) begin
          if (way == WAY_W'(w))          age_nxt[w] = AGE_MAX;
          else if (age_cur[w] > sel_age) age_nxt[w] = age_cur[w] - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Exactly one way holds AGE_MAX, so an OR-reduction replaces a priority encoder.
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_nxt[w] == AGE_MAX) victim = victim | WAY_W'(w);
    end
  end

endmodule

// File: rtl/lru_age_array.sv
// True-LRU replacement state for a set-associative cache: one age permutation
// per set, touch/inval updates, and a registered victim lookup with forwarding.
module lru_age_array
  import lru_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 8,
  localparam int WAY_W = calc_way_w(WAYS),
  localparam int SET_W = calc_set_w(SETS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             inval,
  input  logic [SET_W-1:0] inval_set,
  input  logic [WAY_W-1:0] inval_way,
  input  logic             rd_en,
  input  logic [SET_W-1:0] rd_set,
  output logic             victim_valid,
  output logic [WAY_W-1:0] victim_way
);

  logic [WAYS-1:0][WAY_W-1:0] age_q [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_d [SETS];
  logic [1:0]                 set_op [SETS];
  logic [WAY_W-1:0]           set_way [SETS];
  logic [WAY_W-1:0]           set_victim [SETS];

  logic             victim_valid_q, victim_valid_d;
  logic [WAY_W-1:0] victim_way_q, victim_way_d;
  logic [WAY_W-1:0] victim_sel;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic touch_hit, inval_hit;

    // A touch on the same set wins; the colliding inval is dropped.
    assign touch_hit  = touch && (touch_set == SET_W'(s));
    assign inval_hit  = inval && (inval_set == SET_W'(s));
    assign set_op[s]  = touch_hit ? OP_TOUCH : (inval_hit ? OP_INVAL : OP_NONE);
    assign set_way[s] = touch_hit ? touch_way : inval_way;

    lru_age_set #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
    ) u_set (
      .age_cur (age_q[s]),
      .op      (set_op[s]),
      .way     (set_way[s]),
      .age_nxt (age_d[s]),
      .victim  (set_victim[s])
    );
  end

  always_comb begin
    victim_sel = '0;
    for (int s = 0; s < SETS; s++) begin
      if (rd_set == SET_W'(s)) victim_sel = set_victim[s];
    end
  end

  always_comb begin
    victim_valid_d = rd_en;
    victim_way_d   = rd_en ? victim_sel : victim_way_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(reset_age(w));
        end
      end
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= age_d[s];
      end
      victim_valid_q <= victim_valid_d;
      victim_way_q   <= victim_way_d;
    end
  end

  assign victim_valid = victim_valid_q;
  assign victim_way   = victim_way_q;

endmodule
